lcd_readback: RTL

//  Read-side master for the 4-bit HD44780-style character LCD bus. Reads back the busy

---
 rtl/lcd_readback.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_readback.sv
// lcd_readback: read-side master for the 4-bit HD44780-style character LCD bus.
// Reads back the busy flag / address counter (op=0), or one DDRAM character at a
// 5-bit screen location (op=1, which first writes a set-DDRAM-address command).
// The LCD pins are shared with the write-side controller through a top-level mux
// selected by busy; every pin output sits at its idle value whenever busy is low.
//
// Ports:
//   clk       system clock (single domain)
//   reset     synchronous, active-high
//   start     one-cycle request, accepted only while busy==0
//   op        0 = busy-flag/address read, 1 = DDRAM character read
//   location  character location for op==1 (0-15 line 1, 16-31 line 2)
//   sfDIn     SF_D[11:8] as seen at the pad
//   sfDOut    SF_D[11:8] value driven when sfDOe==1
//   sfDOe     1 = FPGA drives SF_D
//   LCD_E     enable strobe
//   LCD_RS    register select
//   LCD_RW    1 = read, 0 = write
//   busy      transaction in progress; pins owned by this block
//   done      one-cycle pulse; readData valid
//   readData  byte read, {upper nibble, lower nibble}
module lcd_readback #(
  parameter int SETUP      = 2,
  parameter int E_PULSE    = 12,
  parameter int NIBBLE_GAP = 50,
  parameter int CMD_WAIT   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [4:0] location,
  input  logic [3:0] sfDIn,
  output logic [3:0] sfDOut,
  output logic       sfDOe,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       busy,
  output logic       done,
  output logic [7:0] readData
);

  // Phase lengths of each nibble state, counted from the first setup cycle.
  localparam int HI_LEN    = SETUP + E_PULSE + NIBBLE_GAP;
  localparam int AW_LO_LEN = SETUP + E_PULSE + CMD_WAIT;
  localparam int RD_LO_LEN = SETUP + E_PULSE;
  localparam int LONG_LEN  = (HI_LEN > AW_LO_LEN) ? HI_LEN : AW_LO_LEN;
  localparam int CW        = $clog2(LONG_LEN + 1);

  localparam logic [CW-1:0] E_ON      = CW'(SETUP);
  localparam logic [CW-1:0] E_OFF     = CW'(SETUP + E_PULSE);
  localparam logic [CW-1:0] LAST_E    = CW'(SETUP + E_PULSE - 1);
  localparam logic [CW-1:0] HI_END    = CW'(HI_LEN - 1);
  localparam logic [CW-1:0] AW_LO_END = CW'(AW_LO_LEN - 1);
  localparam logic [CW-1:0] RD_LO_END = CW'(RD_LO_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AW_HI = 3'd1,
    AW_LO = 3'd2,
    RD_HI = 3'd3,
    RD_LO = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          op_r, op_s;
  logic [4:0]    loc_r, loc_s;
  logic          accept_s;
  logic [7:0]    cmd_s;
  logic          e_win_s;

  logic          lcd_e_r, lcd_e_s;
  logic          lcd_rs_r, lcd_rs_s;
  logic          lcd_rw_r, lcd_rw_s;
  logic          sf_d_oe_r, sf_d_oe_s;
  logic [3:0]    sf_d_out_r, sf_d_out_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [7:0]    read_data_r;

  // Next-state, phase counter and request latching.
  always_comb begin
    accept_s = 1'b0;
    state_s  = state_r;
    cnt_s    = cnt_r + CW'(1);
    if (((state_r == IDLE) || (state_r == DONE)) && start) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    op_s  = accept_s ? op : op_r;
    loc_s = accept_s ? location : loc_r;
    case (state_r)
      IDLE, DONE: begin
        cnt_s = '0;
        if (accept_s) begin
          state_s = op ? AW_HI : RD_HI;
        end else begin
          state_s = IDLE;
        end
      end
      AW_HI: begin
        if (cnt_r == HI_END) begin
          state_s = AW_LO;
          cnt_s   = '0;
        end else begin
          state_s = AW_HI;
        end
      end
      AW_LO: begin
        if (cnt_r == AW_LO_END) begin
          state_s = RD_HI;
          cnt_s   = '0;
        end else begin
          state_s = AW_LO;
        end
      end
      RD_HI: begin
        if (cnt_r == HI_END) begin
          state_s = RD_LO;
          cnt_s   = '0;
        end else begin
          state_s = RD_HI;
        end
      end
      RD_LO: begin
        // No trailing gap: the cycle after E falls is already DONE.
        if (cnt_r == RD_LO_END) begin
          state_s = DONE;
          cnt_s   = '0;
        end else begin
          state_s = RD_LO;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Pin values for the upcoming cycle, decoded from the next state so that every
  // output comes straight from a flop and E cannot glitch on a state change.
  always_comb begin
    cmd_s      = loc_s[4] ? {4'hC, loc_s[3:0]} : {4'h8, loc_s[3:0]};
    e_win_s    = (cnt_s >= E_ON) && (cnt_s < E_OFF);
    lcd_e_s    = 1'b0;
    lcd_rs_s   = 1'b0;
    lcd_rw_s   = 1'b1;
    sf_d_oe_s  = 1'b0;
    sf_d_out_s = 4'h0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_s)
      AW_HI, AW_LO: begin
        busy_s     = 1'b1;
        lcd_rw_s   = 1'b0;
        sf_d_oe_s  = 1'b1;
        sf_d_out_s = (state_s == AW_HI) ? cmd_s[7:4] : cmd_s[3:0];
        lcd_e_s    = e_win_s;
      end
      RD_HI, RD_LO: begin
        // RW high and the driver released together: the bus is never driven
        // while the LCD may be driving it.
        busy_s   = 1'b1;
        lcd_rs_s = op_s;
        lcd_e_s  = e_win_s;
      end
      DONE: begin
        done_s = 1'b1;
      end
      IDLE: begin
        done_s = 1'b0;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // State, counter, latched request and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_r       <= 1'b0;
      loc_r      <= 5'd0;
      lcd_e_r    <= 1'b0;
      lcd_rs_r   <= 1'b0;
      lcd_rw_r   <= 1'b1;
      sf_d_oe_r  <= 1'b0;
      sf_d_out_r <= 4'h0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      op_r       <= op_s;
      loc_r      <= loc_s;
      lcd_e_r    <= lcd_e_s;
      lcd_rs_r   <= lcd_rs_s;
      lcd_rw_r   <= lcd_rw_s;
      sf_d_oe_r  <= sf_d_oe_s;
      sf_d_out_r <= sf_d_out_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  // Read-data capture in the last E-high cycle of each read nibble. A reset that
  // abandons a transaction leaves already-captured nibbles in place; a reset while
  // idle clears the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (!busy_r) begin
        read_data_r <= 8'h00;
      end else begin
        read_data_r <= read_data_r;
      end
    end else if ((state_r == RD_HI) && (cnt_r == LAST_E)) begin
      read_data_r[7:4] <= sfDIn;
    end else if ((state_r == RD_LO) && (cnt_r == LAST_E)) begin
      read_data_r[3:0] <= sfDIn;
    end else begin
      read_data_r <= read_data_r;
    end
  end

  assign LCD_E    = lcd_e_r;
  assign LCD_RS   = lcd_rs_r;
  assign LCD_RW   = lcd_rw_r;
  assign sfDOe    = sf_d_oe_r;
  assign sfDOut   = sf_d_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign readData = read_data_r;

endmodule
